// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2bin_seq
//  Description : Sequential BCD-to-binary converter (reverse double-dabble).
//                Takes NDIG packed BCD digits plus an optional sign and
//                returns a two's-complement binary value. One bit of the
//                operand is shifted out of the BCD register per SHIFT
//                state, followed by a parallel per-digit correction in CORR.
//                A conversion takes 8*NDIG+1 cycles from the accepted start
//                to the done pulse. An operand containing a non-decimal
//                nibble is rejected after one cycle with err set.
//
//  Parameters  : NDIG      - number of BCD digits (1..8)
//                BIN_W     - magnitude width, 2**BIN_W > 10**NDIG - 1
//                SIGNED_EN - 1: sign_in negates result, 0: sign_in ignored
//
//  Ports       : clk      in   clock, rising edge
//                rst      in   synchronous active-high reset
//                start    in   conversion request, sampled only in IDLE
//                bcd_in   in   packed BCD operand, digit 0 in [3:0]
//                sign_in  in   1 = negative operand
//                busy     out  conversion in progress
//                done     out  one-cycle completion pulse
//                err      out  valid with done, 1 = some digit > 9
//                bin_out  out  two's-complement result, held until next done
//
//  Revision    : 1.0  initial release
// ============================================================================
module bcd2bin_seq #(
    parameter int NDIG      = 4,
    parameter int BIN_W     = 14,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic              sign_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BIN_W:0]    bin_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_W  = 4 * NDIG;           // operand width in bits
    localparam int c_CW = $clog2(c_W + 1);    // shift counter width

    // The conversion is complete once every operand bit has been shifted.
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_W);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SHIFT = 3'd1;
    localparam logic [2:0] c_CORR  = 3'd2;
    localparam logic [2:0] c_FIN   = 3'd3;
    localparam logic [2:0] c_ERR   = 3'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [c_W-1:0]  r_bcd;      // BCD digits being drained, LSB first
    logic [c_W-1:0]  r_acc;      // binary result accumulates from the top
    logic            r_neg;
    logic [c_CW-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [BIN_W:0]  r_bin;

    // ------------------------------------------------------------------------
    // Per-digit logic
    // ------------------------------------------------------------------------
    logic [NDIG-1:0] w_digit_bad;   // incoming nibble outside 0..9
    logic [c_W-1:0]  w_bcd_corr;    // r_bcd after per-digit correction
    logic            w_any_bad;

    genvar gd;
    generate
        for (gd = 0; gd < NDIG; gd++) begin : g_digit
            assign w_digit_bad[gd] = (bcd_in[4*gd+3 -: 4] > 4'd9);

            // After a right shift, the LSB of the next-higher digit lands in
            // bit 3 of this digit with weight 8 instead of 5. Subtracting 3
            // restores the decimal weight. A nibble with bit 3 set is >= 8,
            // and it can never be below 8 in that case, so no wrap occurs.
            assign w_bcd_corr[4*gd+3 -: 4] =
                r_bcd[4*gd+3] ? (r_bcd[4*gd+3 -: 4] - 4'd3) : r_bcd[4*gd+3 -: 4];
        end
    endgenerate

    assign w_any_bad = |w_digit_bad;

    // ------------------------------------------------------------------------
    // Result magnitude and sign
    // ------------------------------------------------------------------------
    logic [BIN_W-1:0] w_mag;
    logic [BIN_W:0]   w_pos;
    logic [BIN_W:0]   w_neg;

    generate
        if (BIN_W > c_W) begin : g_mag_pad
            assign w_mag = {{(BIN_W - c_W){1'b0}}, r_acc};
        end else if (BIN_W == c_W) begin : g_mag_exact
            assign w_mag = r_acc;
        end else begin : g_mag_trunc
            // For legal parameters the accumulator bits above BIN_W are
            // always zero, so they are simply dropped.
            logic w_acc_unused;
            assign w_mag        = r_acc[BIN_W-1:0];
            assign w_acc_unused = ^r_acc[c_W-1:BIN_W];
        end
    endgenerate

    assign w_pos = {1'b0, w_mag};
    assign w_neg = -w_pos;          // -0 naturally yields 0

    // ------------------------------------------------------------------------
    // Control and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_bcd   <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_bin   <= '0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_bcd <= bcd_in;
                        r_acc <= '0;
                        r_neg <= sign_in & SIGNED_EN;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                        if (w_any_bad) begin
                            r_state <= c_ERR;
                        end else begin
                            r_state <= c_SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                c_SHIFT: begin
                    // Logical right shift of the concatenated {bcd, acc}.
                    {r_bcd, r_acc} <= {1'b0, r_bcd, r_acc[c_W-1:1]};
                    r_cnt          <= r_cnt + c_CW'(1);
                    r_state        <= c_CORR;
                end

                c_CORR: begin
                    r_bcd   <= w_bcd_corr;
                    r_state <= (r_cnt == c_CNT_LAST) ? c_FIN : c_SHIFT;
                end

                c_FIN: begin
                    r_bin   <= r_neg ? w_neg : w_pos;
                    r_done  <= 1'b1;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end

                c_ERR: begin
                    r_bin   <= '0;
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign bin_out = r_bin;

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd2bin_seq
//  Description : Self-checking bench for bcd2bin_seq. Instance u_a uses the
//                default 4-digit signed configuration, u_b a 1-digit
//                unsigned configuration. Directed operands with
//                hand-computed results, latency, busy and error behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst;

    logic        start_a;
    logic [15:0] bcd_a;
    logic        sign_a;
    logic        busy_a;
    logic        done_a;
    logic        err_a;
    logic [14:0] bin_a;

    logic        start_b;
    logic [3:0]  bcd_b;
    logic        sign_b;
    logic        busy_b;
    logic        done_b;
    logic        err_b;
    logic [4:0]  bin_b;

    int n_vec = 0;
    int n_err = 0;

    bcd2bin_seq #(.NDIG(4), .BIN_W(14), .SIGNED_EN(1'b1)) u_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start_a),
        .bcd_in  (bcd_a),
        .sign_in (sign_a),
        .busy    (busy_a),
        .done    (done_a),
        .err     (err_a),
        .bin_out (bin_a)
    );

    bcd2bin_seq #(.NDIG(1), .BIN_W(4), .SIGNED_EN(1'b0)) u_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .bcd_in  (bcd_b),
        .sign_in (sign_b),
        .busy    (busy_b),
        .done    (done_b),
        .err     (err_b),
        .bin_out (bin_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion on u_a (sel=0) or u_b (sel=1). exp_lat counts cycles from
    // the accepting edge to the cycle done is seen. poke>=0 pulses a second,
    // different start on u_a at that cycle of the conversion.
    task automatic run_conv(input string tag, input bit sel, input logic [15:0] bcd,
                            input bit sgn, input logic [15:0] exp_bin, input bit exp_err,
                            input int exp_lat, input int poke);
        int          c;
        int          bz;
        bit          seen;
        logic [15:0] bin_done;
        if (sel) begin
            start_b = 1'b1; bcd_b = bcd[3:0]; sign_b = sgn;
        end else begin
            start_a = 1'b1; bcd_a = bcd; sign_a = sgn;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        c = 0; bz = 0; seen = 1'b0;
        while (!seen && c < 200) begin
            if (sel ? done_b : done_a) begin
                seen = 1'b1;
            end else begin
                if (sel ? busy_b : busy_a) bz++;
                if (c == poke) begin
                    start_a = 1'b1; bcd_a = 16'h0777; sign_a = ~sgn;
                end else begin
                    start_a = 1'b0;
                end
                tick();
                c++;
            end
        end
        start_a = 1'b0;
        check({tag, "/done_seen"}, 32'(seen), 32'd1);
        check({tag, "/latency"}, 32'(c), 32'(exp_lat));
        check({tag, "/busy_cycles"}, 32'(bz), exp_err ? 32'd0 : 32'(exp_lat));
        check({tag, "/err"}, 32'(sel ? err_b : err_a), 32'(exp_err));
        check({tag, "/busy_at_done"}, 32'(sel ? busy_b : busy_a), 32'd0);
        bin_done = sel ? 16'(bin_b) : 16'(bin_a);
        check({tag, "/bin"}, 32'(bin_done), 32'(exp_bin));
        if (!sel && !exp_err)
            check({tag, "/acc_hi_zero"}, 32'(u_a.r_acc[15:14]), 32'd0);
        tick();
        check({tag, "/done_pulse"}, 32'(sel ? done_b : done_a), 32'd0);
        check({tag, "/err_hold"}, 32'(sel ? err_b : err_a), 32'(exp_err));
        check({tag, "/bin_hold"}, sel ? 32'(bin_b) : 32'(bin_a), 32'(exp_bin));
    endtask

    initial begin
        int c;
        int nd;
        bit seen;
        rst = 1'b1;
        start_a = 1'b0; bcd_a = '0; sign_a = 1'b0;
        start_b = 1'b0; bcd_b = '0; sign_b = 1'b0;
        repeat (3) tick();
        check("reset/busy_a", 32'(busy_a), 32'd0);
        check("reset/done_a", 32'(done_a), 32'd0);
        check("reset/err_a", 32'(err_a), 32'd0);
        check("reset/bin_a", 32'(bin_a), 32'd0);
        check("reset/bin_b", 32'(bin_b), 32'd0);
        rst = 1'b0;
        tick();

        // T1/T2: valid conversions, 33 cycles each
        run_conv("t1_9999", 1'b0, 16'h9999, 1'b0, 16'h270F, 1'b0, 33, -1);
        run_conv("t2_m1234", 1'b0, 16'h1234, 1'b1, 16'h7B2E, 1'b0, 33, -1);
        run_conv("t2_m0000", 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 33, -1);
        run_conv("p_0042", 1'b0, 16'h0042, 1'b0, 16'h002A, 1'b0, 33, -1);
        run_conv("m_0001", 1'b0, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 33, -1);

        // T3: invalid digits, err after one cycle, busy never high
        run_conv("t3_12A4", 1'b0, 16'h12A4, 1'b0, 16'h0000, 1'b1, 1, -1);
        run_conv("t3_F000", 1'b0, 16'hF000, 1'b1, 16'h0000, 1'b1, 1, -1);

        // T4: second start at cycle 5 is ignored; 500 = 0x1F4
        run_conv("t4_0500", 1'b0, 16'h0500, 1'b0, 16'h01F4, 1'b0, 33, 5);
        nd = 0;
        repeat (40) begin
            if (done_a) nd++;
            tick();
        end
        check("t4/no_extra_done", 32'(nd), 32'd0);

        // start held high: next conversion accepted in the cycle after done
        start_a = 1'b1; bcd_a = 16'h0001; sign_a = 1'b0;
        tick();
        c = 0; seen = 1'b0;
        while (!seen && c < 200) begin
            if (done_a) seen = 1'b1;
            else begin tick(); c++; end
        end
        check("held/first_lat", 32'(c), 32'd33);
        tick();
        start_a = 1'b0;
        c = 1; seen = 1'b0;
        while (!seen && c < 200) begin
            if (done_a) seen = 1'b1;
            else begin tick(); c++; end
        end
        check("held/second_gap", 32'(c), 32'd34);
        check("held/bin", 32'(bin_a), 32'h1);
        tick();

        // T5: reset at cycle 10 aborts the conversion
        start_a = 1'b1; bcd_a = 16'h9999; sign_a = 1'b0;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5/busy", 32'(busy_a), 32'd0);
        check("t5/done", 32'(done_a), 32'd0);
        check("t5/err", 32'(err_a), 32'd0);
        check("t5/bin", 32'(bin_a), 32'd0);
        nd = 0;
        repeat (40) begin
            if (done_a) nd++;
            tick();
        end
        check("t5/no_done", 32'(nd), 32'd0);
        run_conv("t5_0042", 1'b0, 16'h0042, 1'b0, 16'h002A, 1'b0, 33, -1);

        // T6: 1-digit unsigned instance, sign ignored, 9 cycles each
        for (int d = 0; d < 10; d++)
            run_conv($sformatf("t6_d%0d", d), 1'b1, 16'(d), 1'b1, 16'(d), 1'b0, 9, -1);
        run_conv("t6_bad", 1'b1, 16'h000B, 1'b1, 16'h0000, 1'b1, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
